// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/hazard bus between the ID stage and the pipeline hazard controller.
// The master side presents the decode instruction and pipeline controls; the
// slave side (the hazard controller) returns stall/flush/issue and bypass selects.
interface pipe_hazard_ctrl_if #(
   parameter int DEPTH = 3,
   parameter int RAW   = 5
);
   logic             id_valid;
   logic [RAW-1:0]   id_rs1;
   logic [RAW-1:0]   id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [RAW-1:0]   id_rd;
   logic             id_wen;
   logic             id_is_load;
   logic             ex_redirect;
   logic             pipe_hold;
   logic             stall;
   logic             flush_if_id;
   logic             issue;
   logic [DEPTH-1:0] stage_valid;
   logic [3:0]       fwd_sel_rs1;
   logic [3:0]       fwd_sel_rs2;
   logic [31:0]      stall_cnt;
   logic [31:0]      flush_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_wen, id_is_load, ex_redirect, pipe_hold,
      input  stall, flush_if_id, issue, stage_valid,
             fwd_sel_rs1, fwd_sel_rs2, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_wen, id_is_load, ex_redirect, pipe_hold,
      output stall, flush_if_id, issue, stage_valid,
             fwd_sel_rs1, fwd_sel_rs2, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks {valid, rd, wen, is_load} for DEPTH
// post-decode stages, detects RAW/load-use hazards for the decode instruction,
// and arbitrates hold / redirect / stall / issue.
// Build option PIPE_FWD_EN: when defined, operands are bypassed from the
// youngest matching stage and only too-young loads stall; when undefined the
// register file does not bypass, so any in-flight producer stalls decode.
// The interface instance must use the same DEPTH and RAW as this module.
module pipe_hazard_ctrl #(
   parameter int DEPTH    = 3,
   parameter int RAW      = 5,
   parameter int LOAD_LAT = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   pipe_hazard_ctrl_if.slave bus
);

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   logic [DEPTH-1:0] valid_r;
   logic [DEPTH-1:0] wen_r;
   logic [DEPTH-1:0] load_r;
   logic [RAW-1:0]   rd_r [DEPTH];
   logic [31:0]      stall_cnt_r;
   logic [31:0]      flush_cnt_r;

   logic [DEPTH-1:0] hit1_s;
   logic [DEPTH-1:0] hit2_s;
   logic             hazard_s;
   logic [3:0]       fwd1_s;
   logic [3:0]       fwd2_s;
   logic             stall_s;
   logic             flush_s;
   logic             issue_s;

   // Compare each used, non-x0 source against every in-flight writer.
   always_comb begin
      hit1_s = {DEPTH{1'b0}};
      hit2_s = {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         hit1_s[k] = bus.id_rs1_used && (bus.id_rs1 != {RAW{1'b0}}) &&
                     valid_r[k] && wen_r[k] && (rd_r[k] == bus.id_rs1);
         hit2_s[k] = bus.id_rs2_used && (bus.id_rs2 != {RAW{1'b0}}) &&
                     valid_r[k] && wen_r[k] && (rd_r[k] == bus.id_rs2);
      end
   end

`ifdef PIPE_FWD_EN
   logic [3:0] sel1_s;
   logic [3:0] sel2_s;
   logic       young1_s;
   logic       young2_s;

   // Pick the youngest producer per source; scanning old-to-young lets the
   // lowest stage index overwrite older matches.
   always_comb begin
      sel1_s   = 4'd0;
      sel2_s   = 4'd0;
      young1_s = 1'b0;
      young2_s = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         sel1_s   = hit1_s[k] ? 4'(k + 1) : sel1_s;
         young1_s = hit1_s[k] ? (load_r[k] && (k < LOAD_LAT)) : young1_s;
         sel2_s   = hit2_s[k] ? 4'(k + 1) : sel2_s;
         young2_s = hit2_s[k] ? (load_r[k] && (k < LOAD_LAT)) : young2_s;
      end
   end

   assign hazard_s = young1_s | young2_s;
   assign fwd1_s   = sel1_s;
   assign fwd2_s   = sel2_s;
`else
   // Without bypass the load flag and load latency never affect the decision.
   logic cfg_unused_s;
   assign cfg_unused_s = (^load_r) ^ (LOAD_LAT < DEPTH);

   assign hazard_s = (|hit1_s) | (|hit2_s);
   assign fwd1_s   = 4'd0;
   assign fwd2_s   = 4'd0;
`endif

   // Arbitrate reset, hold, redirect, hazard and normal issue in priority order.
   always_comb begin
      stall_s = 1'b0;
      flush_s = 1'b0;
      issue_s = 1'b0;
      if (sys_rst) begin
         stall_s = 1'b0;
         flush_s = 1'b0;
         issue_s = 1'b0;
      end else if (bus.pipe_hold) begin
         stall_s = 1'b1;
      end else if (bus.ex_redirect) begin
         flush_s = 1'b1;
      end else if (bus.id_valid && hazard_s) begin
         stall_s = 1'b1;
      end else begin
         issue_s = bus.id_valid;
      end
   end

   // Advance the stage tuples unless frozen; stage 0 gets the issued op or a bubble.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         valid_r <= {DEPTH{1'b0}};
         wen_r   <= {DEPTH{1'b0}};
         load_r  <= {DEPTH{1'b0}};
         for (int k = 0; k < DEPTH; k++) begin
            rd_r[k] <= {RAW{1'b0}};
         end
      end else if (!bus.pipe_hold) begin
         valid_r <= {valid_r[DEPTH-2:0], issue_s};
         wen_r   <= {wen_r[DEPTH-2:0],
                     issue_s & bus.id_wen & (bus.id_rd != {RAW{1'b0}})};
         load_r  <= {load_r[DEPTH-2:0], issue_s & bus.id_is_load};
         rd_r[0] <= issue_s ? bus.id_rd : {RAW{1'b0}};
         for (int k = 1; k < DEPTH; k++) begin
            rd_r[k] <= rd_r[k-1];
         end
      end
   end

   // Saturating stall/flush event counters; a held pipe does not count stalls.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (stall_s && !bus.pipe_hold && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if (flush_s && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end
      end
   end

   assign bus.stall       = stall_s;
   assign bus.flush_if_id = flush_s;
   assign bus.issue       = issue_s;
   assign bus.stage_valid = valid_r;
   assign bus.fwd_sel_rs1 = sys_rst ? 4'd0 : fwd1_s;
   assign bus.fwd_sel_rs2 = sys_rst ? 4'd0 : fwd2_s;
   assign bus.stall_cnt   = stall_cnt_r;
   assign bus.flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (DEPTH=3, RAW=5, LOAD_LAT=2).
// A behavioural pipeline model pushes expected outputs to a scoreboard queue
// every cycle; directed scenario tasks add their own explicit checks.
module tb_pipe_hazard_ctrl;
   localparam int DEPTH    = 3;
   localparam int RAW      = 5;
   localparam int LOAD_LAT = 2;

`ifdef PIPE_FWD_EN
   localparam int         ALU_STALLS  = 0;
   localparam int         LOAD_STALLS = 2;
   localparam logic [3:0] ALU_FWD     = 4'd1;
   localparam logic [3:0] LOAD_FWD    = 4'd3;
`else
   localparam int         ALU_STALLS  = 3;
   localparam int         LOAD_STALLS = 3;
   localparam logic [3:0] ALU_FWD     = 4'd0;
   localparam logic [3:0] LOAD_FWD    = 4'd0;
`endif

   typedef struct {
      logic             stall;
      logic             flush;
      logic             issue;
      logic [3:0]       f1;
      logic [3:0]       f2;
      logic [DEPTH-1:0] sv;
      logic [31:0]      sc;
      logic [31:0]      fc;
   } exp_t;

   logic sys_clk;
   logic sys_rst;
   int   checks = 0;
   int   errors = 0;

   exp_t sb[$];
   exp_t cur;

   logic [DEPTH-1:0] mv;
   logic [DEPTH-1:0] mwen;
   logic [DEPTH-1:0] mld;
   logic [RAW-1:0]   mrd [DEPTH];
   logic [31:0]      msc;
   logic [31:0]      mfc;

   pipe_hazard_ctrl_if #(.DEPTH(DEPTH), .RAW(RAW)) bus ();

   pipe_hazard_ctrl #(.DEPTH(DEPTH), .RAW(RAW), .LOAD_LAT(LOAD_LAT)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_clear();
      mv  = '0;
      mwen = '0;
      mld = '0;
      msc = 32'd0;
      mfc = 32'd0;
      for (int k = 0; k < DEPTH; k++) mrd[k] = '0;
   endfunction

   // Expected bypass select and hazard for one source, youngest stage first.
   function automatic void src_eval(input logic used, input logic [RAW-1:0] a,
                                    output logic [3:0] sel, output logic haz);
      sel = 4'd0;
      haz = 1'b0;
      if (used && a != '0) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (mv[k] && mwen[k] && mrd[k] == a) begin
`ifdef PIPE_FWD_EN
               sel = 4'(k + 1);
               haz = mld[k] && (k < LOAD_LAT);
`else
               haz = 1'b1;
`endif
               break;
            end
         end
      end
   endfunction

   task automatic set_id(input logic v, input logic [RAW-1:0] rs1, input logic u1,
                         input logic [RAW-1:0] rs2, input logic u2,
                         input logic [RAW-1:0] rd, input logic wen, input logic ld);
      bus.id_valid    = v;
      bus.id_rs1      = rs1;
      bus.id_rs1_used = u1;
      bus.id_rs2      = rs2;
      bus.id_rs2_used = u2;
      bus.id_rd       = rd;
      bus.id_wen      = wen;
      bus.id_is_load  = ld;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      bus.pipe_hold   = 1'b0;
      bus.ex_redirect = 1'b0;
   endtask

   // Let inputs settle, push the model's expectation, then pop and compare.
   task automatic settle();
      exp_t e;
      logic h1, h2;
      #1;
      src_eval(bus.id_rs1_used, bus.id_rs1, e.f1, h1);
      src_eval(bus.id_rs2_used, bus.id_rs2, e.f2, h2);
      e.stall = 1'b0; e.flush = 1'b0; e.issue = 1'b0;
      if (bus.pipe_hold) e.stall = 1'b1;
      else if (bus.ex_redirect) e.flush = 1'b1;
      else if (bus.id_valid && (h1 || h2)) e.stall = 1'b1;
      else e.issue = bus.id_valid;
      e.sv = mv; e.sc = msc; e.fc = mfc;
      sb.push_back(e);
      cur = sb.pop_front();
      checks++;
      if ({bus.stall, bus.flush_if_id, bus.issue} !== {cur.stall, cur.flush, cur.issue}) begin
         errors++;
         $display("FAIL sb_ctrl t=%0t: stall/flush/issue got %b%b%b want %b%b%b", $time,
                  bus.stall, bus.flush_if_id, bus.issue, cur.stall, cur.flush, cur.issue);
      end
      checks++;
      if ({bus.fwd_sel_rs1, bus.fwd_sel_rs2} !== {cur.f1, cur.f2}) begin
         errors++;
         $display("FAIL sb_fwd t=%0t: rs1/rs2 got %0d/%0d want %0d/%0d", $time,
                  bus.fwd_sel_rs1, bus.fwd_sel_rs2, cur.f1, cur.f2);
      end
      checks++;
      if ({bus.stage_valid, bus.stall_cnt, bus.flush_cnt} !== {cur.sv, cur.sc, cur.fc}) begin
         errors++;
         $display("FAIL sb_state t=%0t: sv/sc/fc got %b/%0d/%0d want %b/%0d/%0d", $time,
                  bus.stage_valid, bus.stall_cnt, bus.flush_cnt, cur.sv, cur.sc, cur.fc);
      end
   endtask

   // Advance the model across the coming rising edge and wait for the next low phase.
   task automatic tick();
      if (!bus.pipe_hold) begin
         if (cur.stall && msc != 32'hFFFF_FFFF) msc = msc + 32'd1;
         if (cur.flush && mfc != 32'hFFFF_FFFF) mfc = mfc + 32'd1;
         for (int k = DEPTH - 1; k > 0; k--) begin
            mv[k] = mv[k-1]; mwen[k] = mwen[k-1]; mld[k] = mld[k-1]; mrd[k] = mrd[k-1];
         end
         mv[0]   = cur.issue;
         mrd[0]  = cur.issue ? bus.id_rd : '0;
         mwen[0] = cur.issue && bus.id_wen && (bus.id_rd != '0);
         mld[0]  = cur.issue && bus.id_is_load;
      end
      @(negedge sys_clk);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      idle();
      repeat (2) @(negedge sys_clk);
      model_clear();
      sys_rst = 1'b0;
   endtask

   // Step until the decode instruction issues; returns the number of stall cycles.
   task automatic issue_wait(input int max_cyc, output int stalls);
      stalls = 0;
      for (int i = 0; i < max_cyc; i++) begin
         settle();
         if (bus.issue === 1'b1) break;
         stalls++;
         tick();
      end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      idle();
      bus.id_valid    = 1'b1;
      bus.ex_redirect = 1'b1;
      #1;
      checks++;
      if ({bus.stall, bus.flush_if_id, bus.issue, bus.fwd_sel_rs1, bus.fwd_sel_rs2} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got stall=%b flush=%b issue=%b f1=%0d f2=%0d want all 0",
                  bus.stall, bus.flush_if_id, bus.issue, bus.fwd_sel_rs1, bus.fwd_sel_rs2);
      end
      checks++;
      if ({bus.stage_valid, bus.stall_cnt, bus.flush_cnt} !== 67'd0) begin
         errors++;
         $display("FAIL reset_state: got sv=%b sc=%0d fc=%0d want 0", bus.stage_valid,
                  bus.stall_cnt, bus.flush_cnt);
      end
      do_reset();
   endtask

   task automatic test_fwd_alu();
      int n;
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5,x1,x2
      settle(); tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);  // sub x6,x5,x1
      issue_wait(8, n);
      checks++;
      if (n != ALU_STALLS) begin errors++; $display("FAIL alu_stalls: got %0d want %0d", n, ALU_STALLS); end
      checks++;
      if (bus.fwd_sel_rs1 !== ALU_FWD) begin
         errors++; $display("FAIL alu_fwd_rs1: got %0d want %0d", bus.fwd_sel_rs1, ALU_FWD);
      end
      checks++;
      if (bus.stall_cnt !== 32'(ALU_STALLS)) begin
         errors++; $display("FAIL alu_stall_cnt: got %0d want %0d", bus.stall_cnt, ALU_STALLS);
      end
      tick(); idle(); settle(); tick();
   endtask

   task automatic test_load_use();
      int n;
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);  // ld x7
      settle(); tick();
      set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);  // add x8,x7,x7
      issue_wait(8, n);
      checks++;
      if (n != LOAD_STALLS) begin errors++; $display("FAIL load_stalls: got %0d want %0d", n, LOAD_STALLS); end
      checks++;
      if ({bus.fwd_sel_rs1, bus.fwd_sel_rs2} !== {LOAD_FWD, LOAD_FWD}) begin
         errors++; $display("FAIL load_fwd: got %0d/%0d want %0d/%0d", bus.fwd_sel_rs1,
                            bus.fwd_sel_rs2, LOAD_FWD, LOAD_FWD);
      end
      checks++;
      if (bus.stall_cnt !== 32'(LOAD_STALLS)) begin
         errors++; $display("FAIL load_stall_cnt: got %0d want %0d", bus.stall_cnt, LOAD_STALLS);
      end
      tick(); idle(); settle(); tick();
   endtask

   task automatic test_redirect();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);  // ld x7
      settle(); tick();
      set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      bus.ex_redirect = 1'b1;
      settle();
      checks++;
      if ({bus.flush_if_id, bus.stall, bus.issue} !== 3'b100) begin
         errors++; $display("FAIL redirect_ctrl: flush/stall/issue got %b%b%b want 100",
                            bus.flush_if_id, bus.stall, bus.issue);
      end
      tick();
      idle();
      settle();
      checks++;
      if (bus.stage_valid[0] !== 1'b0 || bus.flush_cnt !== 32'd1) begin
         errors++; $display("FAIL redirect_after: sv0=%b fc=%0d want sv0=0 fc=1",
                            bus.stage_valid[0], bus.flush_cnt);
      end
      tick();
   endtask

   task automatic test_x0();
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // addi x0,x1
      settle(); tick();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);  // add x9,x0,x0
      settle();
      checks++;
      if ({bus.stall, bus.issue, bus.fwd_sel_rs1, bus.fwd_sel_rs2} !== {1'b0, 1'b1, 8'd0}) begin
         errors++; $display("FAIL x0_consumer: stall=%b issue=%b f1=%0d f2=%0d want 0 1 0 0",
                            bus.stall, bus.issue, bus.fwd_sel_rs1, bus.fwd_sel_rs2);
      end
      tick(); idle(); settle(); tick();
   endtask

   task automatic test_hold();
      int n;
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);  // ld x9
      settle(); tick();
      set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
      settle(); tick();
      bus.pipe_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         checks++;
         if ({bus.stall, bus.issue, bus.stage_valid, bus.stall_cnt} !== {1'b1, 1'b0, 3'b010, 32'd1}) begin
            errors++; $display("FAIL hold_cycle%0d: stall=%b issue=%b sv=%b sc=%0d want 1 0 010 1",
                               i, bus.stall, bus.issue, bus.stage_valid, bus.stall_cnt);
         end
         tick();
      end
      bus.pipe_hold = 1'b0;
      issue_wait(8, n);
      checks++;
      if (bus.issue !== 1'b1) begin errors++; $display("FAIL hold_release: issue got %b want 1", bus.issue); end
      tick(); idle(); settle(); tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); settle(); tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); settle(); tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); settle(); tick();
      set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      settle();
      checks++;
      if ({bus.stage_valid, bus.stall} !== 4'b1111) begin
         errors++; $display("FAIL rstmid_pre: sv=%b stall=%b want 111 1", bus.stage_valid, bus.stall);
      end
      #2 sys_rst = 1'b1;
      #1;
      checks++;
      if ({bus.stage_valid, bus.stall, bus.issue, bus.stall_cnt} !== {3'b000, 1'b0, 1'b0, 32'd0}) begin
         errors++; $display("FAIL rstmid_during: sv=%b stall=%b issue=%b sc=%0d want 000 0 0 0",
                            bus.stage_valid, bus.stall, bus.issue, bus.stall_cnt);
      end
      @(negedge sys_clk);
      model_clear();
      sys_rst = 1'b0;
      settle();
      checks++;
      if ({bus.stall, bus.issue} !== 2'b01) begin
         errors++; $display("FAIL rstmid_after: stall=%b issue=%b want 0 1", bus.stall, bus.issue);
      end
      tick(); idle(); settle(); tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 120; i++) begin
         set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         bus.pipe_hold   = ($urandom_range(0, 7) == 0);
         bus.ex_redirect = ($urandom_range(0, 7) == 0);
         settle();
         tick();
      end
      idle(); settle(); tick();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_fwd_alu();
      test_load_use();
      test_redirect();
      test_x0();
      test_hold();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
